bpfvm_ctrl_lat: RTL

- Parametrised successor to the BPF CPU control FSM. Drives the same datapath select/enable lines as the single-cycle controller.
- Supports code memory and packet memory with configurable multi-cycle read latency.
- Enforces a runtime instruction budget; on exhaustion the program is forcibly rejected.
- Holds the accept/reject verdict until the packet-memory side acknowledges it.
- Sits between the instruction/packet memories and the bpfvm datapath.

---
 rtl/bpfvm_ctrl_lat_if.sv | 41 ++++
 rtl/bpfvm_ctrl_lat.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpfvm_ctrl_lat_if.sv
// Control and flag bundle between the BPF control FSM and the bpfvm datapath.
interface bpfvm_ctrl_lat_if;
    logic [15:0] opcode;
    logic        set;
    logic        eq;
    logic        gt;
    logic        ge;
    logic        A_is_zero;
    logic        X_is_zero;
    logic        imm_is_zero;

    logic [2:0]  A_sel;
    logic [2:0]  X_sel;
    logic [1:0]  PC_sel;
    logic        addr_sel;
    logic        regfile_sel;
    logic        B_sel;
    logic [3:0]  ALU_sel;
    logic [1:0]  transfer_sz;
    logic        A_en;
    logic        X_en;
    logic        PC_en;
    logic        PC_rst;
    logic        regfile_wr_en;
    logic        packet_mem_rd_en;
    logic        inst_mem_rd_en;

    modport master (
        input  opcode, set, eq, gt, ge, A_is_zero, X_is_zero, imm_is_zero,
        output A_sel, X_sel, PC_sel, addr_sel, regfile_sel, B_sel, ALU_sel,
               transfer_sz, A_en, X_en, PC_en, PC_rst, regfile_wr_en,
               packet_mem_rd_en, inst_mem_rd_en
    );

    modport slave (
        output opcode, set, eq, gt, ge, A_is_zero, X_is_zero, imm_is_zero,
        input  A_sel, X_sel, PC_sel, addr_sel, regfile_sel, B_sel, ALU_sel,
               transfer_sz, A_en, X_en, PC_en, PC_rst, regfile_wr_en,
               packet_mem_rd_en, inst_mem_rd_en
    );
endinterface

// File: rtl/bpfvm_ctrl_lat.sv
// BPF CPU control FSM with multi-cycle code/packet memory latency,
// a runtime instruction budget and a verdict held until acknowledged.
module bpfvm_ctrl_lat #(
    parameter int CODE_LAT = 1,
    parameter int PACK_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    bpfvm_ctrl_lat_if.master dp,
    input  logic             mem_ready,
    input  logic [CNT_W-1:0] max_insns,
    input  logic             result_ack,
    output logic             accept,
    output logic             reject,
    output logic             timed_out,
    output logic [CNT_W-1:0] insn_count
);
    // Opcode fields and select encodings follow the bpf_defs.vh layout
    localparam logic [2:0] CLS_LD   = 3'd0;
    localparam logic [2:0] CLS_LDX  = 3'd1;
    localparam logic [2:0] CLS_ST   = 3'd2;
    localparam logic [2:0] CLS_STX  = 3'd3;
    localparam logic [2:0] CLS_ALU  = 3'd4;
    localparam logic [2:0] CLS_JMP  = 3'd5;
    localparam logic [2:0] CLS_RET  = 3'd6;
    localparam logic [2:0] CLS_MISC = 3'd7;

    localparam logic [2:0] MODE_IMM = 3'd0;
    localparam logic [2:0] MODE_ABS = 3'd1;
    localparam logic [2:0] MODE_IND = 3'd2;
    localparam logic [2:0] MODE_MEM = 3'd3;
    localparam logic [2:0] MODE_LEN = 3'd4;
    localparam logic [2:0] MODE_MSH = 3'd5;

    localparam logic [3:0] JMP_JA   = 4'd0;
    localparam logic [3:0] JMP_JEQ  = 4'd1;
    localparam logic [3:0] JMP_JGT  = 4'd2;
    localparam logic [3:0] JMP_JGE  = 4'd3;
    localparam logic [3:0] JMP_JSET = 4'd4;

    localparam logic [1:0] RET_IMM = 2'd0;
    localparam logic [1:0] RET_X   = 2'd1;
    localparam logic [1:0] RET_A   = 2'd2;

    localparam logic [2:0] A_SEL_IMM        = 3'd0;
    localparam logic [2:0] A_SEL_PACKET_MEM = 3'd1;
    localparam logic [2:0] A_SEL_MEM        = 3'd2;
    localparam logic [2:0] A_SEL_LEN        = 3'd3;
    localparam logic [2:0] A_SEL_ALU        = 3'd4;
    localparam logic [2:0] A_SEL_X          = 3'd5;

    localparam logic [2:0] X_SEL_IMM        = 3'd0;
    localparam logic [2:0] X_SEL_PACKET_MEM = 3'd1;
    localparam logic [2:0] X_SEL_MEM        = 3'd2;
    localparam logic [2:0] X_SEL_LEN        = 3'd3;
    localparam logic [2:0] X_SEL_MSH        = 3'd4;
    localparam logic [2:0] X_SEL_A          = 3'd5;

    localparam logic [1:0] PC_SEL_PLUS_1   = 2'd0;
    localparam logic [1:0] PC_SEL_PLUS_IMM = 2'd1;
    localparam logic [1:0] PC_SEL_PLUS_JT  = 2'd2;
    localparam logic [1:0] PC_SEL_PLUS_JF  = 2'd3;

    localparam logic PACK_ADDR_ABS = 1'b0;
    localparam logic PACK_ADDR_IND = 1'b1;
    localparam logic REGFILE_IN_A  = 1'b0;
    localparam logic REGFILE_IN_X  = 1'b1;

    localparam int MAX_LAT = (CODE_LAT > PACK_LAT) ? CODE_LAT : PACK_LAT;
    localparam int WAIT_W  = (MAX_LAT > 2) ? $clog2(MAX_LAT - 1) : 1;
    localparam logic [WAIT_W-1:0] CODE_WAIT = WAIT_W'((CODE_LAT > 1) ? CODE_LAT - 2 : 0);
    localparam logic [WAIT_W-1:0] PACK_WAIT = WAIT_W'((PACK_LAT > 1) ? PACK_LAT - 2 : 0);

    typedef enum logic [3:0] {
        RESET, FETCH, FETCH_WAIT, DECODE, PMEM_WAIT,
        WR_MEM_A, WR_MEM_X, MSH_MEM_X, WR_ALU_A, RESULT
    } state_t;

    state_t            state_q, state_d;
    state_t            dest_q, dest_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  budget_q, budget_d;
    logic [CNT_W-1:0]  count_d;
    logic              accept_d, reject_d, timed_out_d;

    logic [2:0] cls;
    logic [2:0] mode;
    logic [3:0] jmp_op;
    logic [1:0] rval;
    logic       pmem_go;
    state_t     pmem_dst;
    logic       illegal;
    logic       ret_zero;
    logic       jmp_taken;

    assign cls    = dp.opcode[2:0];
    assign mode   = dp.opcode[7:5];
    assign jmp_op = dp.opcode[7:4];
    assign rval   = dp.opcode[4:3];

    assign dp.B_sel       = dp.opcode[3];
    assign dp.ALU_sel     = dp.opcode[7:4];
    assign dp.transfer_sz = dp.opcode[4:3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RESET;
            dest_q     <= WR_MEM_A;
            wait_q     <= '0;
            budget_q   <= '0;
            insn_count <= '0;
            accept     <= 1'b0;
            reject     <= 1'b0;
            timed_out  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            wait_q     <= wait_d;
            budget_q   <= budget_d;
            insn_count <= count_d;
            accept     <= accept_d;
            reject     <= reject_d;
            timed_out  <= timed_out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        wait_d      = wait_q;
        budget_d    = budget_q;
        count_d     = insn_count;
        accept_d    = accept;
        reject_d    = reject;
        timed_out_d = timed_out;

        pmem_go   = 1'b0;
        pmem_dst  = WR_MEM_A;
        illegal   = 1'b0;
        ret_zero  = 1'b1;
        jmp_taken = 1'b0;

        dp.A_sel            = A_SEL_IMM;
        dp.X_sel            = X_SEL_IMM;
        dp.PC_sel           = PC_SEL_PLUS_1;
        dp.addr_sel         = PACK_ADDR_ABS;
        dp.regfile_sel      = REGFILE_IN_A;
        dp.A_en             = 1'b0;
        dp.X_en             = 1'b0;
        dp.PC_en            = 1'b0;
        dp.PC_rst           = 1'b0;
        dp.regfile_wr_en    = 1'b0;
        dp.packet_mem_rd_en = 1'b0;
        dp.inst_mem_rd_en   = 1'b0;

        unique case (state_q)
            RESET: begin
                dp.PC_rst = 1'b1;
                if (mem_ready) begin
                    state_d  = FETCH;
                    budget_d = max_insns;
                    count_d  = '0;
                end
            end
            FETCH: begin
                dp.inst_mem_rd_en = 1'b1;
                dp.PC_en          = 1'b1;
                dp.PC_sel         = PC_SEL_PLUS_1;
                if (CODE_LAT == 1) begin
                    state_d = DECODE;
                end else begin
                    state_d = FETCH_WAIT;
                    wait_d  = CODE_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (wait_q == '0) state_d = DECODE;
                else              wait_d  = wait_q - 1'b1;
            end
            DECODE: begin
                count_d = (&insn_count) ? insn_count : insn_count + 1'b1;
                state_d = FETCH;
                unique case (cls)
                    CLS_LD, CLS_LDX: begin
                        unique case (mode)
                            MODE_IMM, MODE_MEM, MODE_LEN: begin
                                if (cls == CLS_LD) begin
                                    dp.A_en  = 1'b1;
                                    dp.A_sel = (mode == MODE_IMM) ? A_SEL_IMM :
                                               (mode == MODE_MEM) ? A_SEL_MEM : A_SEL_LEN;
                                end else begin
                                    dp.X_en  = 1'b1;
                                    dp.X_sel = (mode == MODE_IMM) ? X_SEL_IMM :
                                               (mode == MODE_MEM) ? X_SEL_MEM : X_SEL_LEN;
                                end
                            end
                            MODE_ABS, MODE_IND: begin
                                pmem_go  = 1'b1;
                                pmem_dst = (cls == CLS_LD) ? WR_MEM_A : WR_MEM_X;
                            end
                            MODE_MSH: begin
                                if (cls == CLS_LDX) begin
                                    pmem_go  = 1'b1;
                                    pmem_dst = MSH_MEM_X;
                                end else begin
                                    illegal = 1'b1;
                                end
                            end
                            default: illegal = 1'b1;
                        endcase
                    end
                    CLS_ST, CLS_STX: begin
                        dp.regfile_wr_en = 1'b1;
                        dp.regfile_sel   = (cls == CLS_STX) ? REGFILE_IN_X : REGFILE_IN_A;
                    end
                    CLS_ALU: state_d = WR_ALU_A;
                    CLS_JMP: begin
                        dp.PC_en = 1'b1;
                        unique case (jmp_op)
                            JMP_JEQ:  jmp_taken = dp.eq;
                            JMP_JGT:  jmp_taken = dp.gt;
                            JMP_JGE:  jmp_taken = dp.ge;
                            JMP_JSET: jmp_taken = dp.set;
                            default:  jmp_taken = 1'b0;
                        endcase
                        if (jmp_op == JMP_JA) dp.PC_sel = PC_SEL_PLUS_IMM;
                        else if (jmp_taken)   dp.PC_sel = PC_SEL_PLUS_JT;
                        else                  dp.PC_sel = PC_SEL_PLUS_JF;
                    end
                    CLS_RET: begin
                        state_d = RESULT;
                        unique case (rval)
                            RET_IMM: ret_zero = dp.imm_is_zero;
                            RET_X:   ret_zero = dp.X_is_zero;
                            RET_A:   ret_zero = dp.A_is_zero;
                            default: ret_zero = 1'b1;
                        endcase
                        if (ret_zero) reject_d = 1'b1;
                        else          accept_d = 1'b1;
                    end
                    CLS_MISC: begin
                        if (dp.opcode[7:3] == 5'd0) begin
                            dp.X_en  = 1'b1;
                            dp.X_sel = X_SEL_A;
                        end else begin
                            dp.A_en  = 1'b1;
                            dp.A_sel = A_SEL_X;
                        end
                    end
                    default: illegal = 1'b1;
                endcase

                if (pmem_go) begin
                    dp.packet_mem_rd_en = 1'b1;
                    dp.addr_sel = (mode == MODE_IND) ? PACK_ADDR_IND : PACK_ADDR_ABS;
                    if (PACK_LAT == 1) begin
                        state_d = pmem_dst;
                    end else begin
                        state_d = PMEM_WAIT;
                        dest_d  = pmem_dst;
                        wait_d  = PACK_WAIT;
                    end
                end

                if (illegal) begin
                    state_d  = RESULT;
                    reject_d = 1'b1;
                end

                // Budget exhaustion overrides the next state but not this cycle's enables
                if (budget_q != '0 && count_d == budget_q && cls != CLS_RET) begin
                    state_d     = RESULT;
                    accept_d    = 1'b0;
                    reject_d    = 1'b1;
                    timed_out_d = 1'b1;
                end
            end
            PMEM_WAIT: begin
                if (wait_q == '0) state_d = dest_q;
                else              wait_d  = wait_q - 1'b1;
            end
            WR_MEM_A: begin
                dp.A_en  = 1'b1;
                dp.A_sel = A_SEL_PACKET_MEM;
                state_d  = FETCH;
            end
            WR_MEM_X: begin
                dp.X_en  = 1'b1;
                dp.X_sel = X_SEL_PACKET_MEM;
                state_d  = FETCH;
            end
            MSH_MEM_X: begin
                dp.X_en  = 1'b1;
                dp.X_sel = X_SEL_MSH;
                state_d  = FETCH;
            end
            WR_ALU_A: begin
                dp.A_en  = 1'b1;
                dp.A_sel = A_SEL_ALU;
                state_d  = FETCH;
            end
            RESULT: begin
                if (result_ack) begin
                    accept_d    = 1'b0;
                    reject_d    = 1'b0;
                    timed_out_d = 1'b0;
                    state_d     = RESET;
                end
            end
            default: state_d = RESET;
        endcase
    end
endmodule
